dipsw_cfg_ctrl: RTL

Debounces a bank of board DIP switches with one shared millisecond timebase and turns switch changes into configuration updates. Each update is committed through a four-phase request/acknowledge handshake to the configuration consumer. The block sits between the raw switch pins and the LVDS/output configuration registers. It is the single place where switch settings become committed configuration, including the initial commit after reset.

---
 rtl/dipsw_cfg_ctrl_if.sv | 33 +++
 rtl/dipsw_cfg_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/dipsw_cfg_ctrl_if.sv
// Switch-to-configuration bus: raw switch pins in, debounced state and commit handshake out.
// No latency of its own; it only bundles the signals.
// The consumer paces commits by holding CFG_ACK low; the DUT holds CFG_REQ/CFG_DATA until acknowledged.
interface dipsw_cfg_ctrl_if #(
    parameter int P_WIDTH = 8
);
    logic [P_WIDTH-1:0] SW_IN;
    logic               CFG_ACK;
    logic               CFG_REQ;
    logic [P_WIDTH-1:0] CFG_DATA;
    logic               CFG_VALID;
    logic [P_WIDTH-1:0] SW_STATE;

    // Board / consumer side
    modport master (
        output SW_IN,
        output CFG_ACK,
        input  CFG_REQ,
        input  CFG_DATA,
        input  CFG_VALID,
        input  SW_STATE
    );

    // Controller side
    modport slave (
        input  SW_IN,
        input  CFG_ACK,
        output CFG_REQ,
        output CFG_DATA,
        output CFG_VALID,
        output SW_STATE
    );
endinterface

// File: rtl/dipsw_cfg_ctrl.sv
// Debounces DIP switches on a shared ms tick and commits settled changes via a 4-phase req/ack.
// Latency: 3 clk sync, P_STABLE ticks debounce, P_SETTLE ticks settle before CFG_REQ.
// Backpressure: CFG_REQ/CFG_DATA held until CFG_ACK; switch changes meanwhile re-settle afterwards.
module dipsw_cfg_ctrl #(
    parameter int          P_WIDTH  = 8,
    parameter logic [19:0] P_TICK   = 20'd65999,
    parameter logic [3:0]  P_STABLE = 4'd10,
    parameter logic [7:0]  P_SETTLE = 8'd50
) (
    input  logic              SYS_CLK,
    input  logic              SYS_xRST,
    dipsw_cfg_ctrl_if.slave   if_cfg
);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_SETTLE,
        S_REQ,
        S_ACKLOW
    } state_t;

    logic [P_WIDTH-1:0] r_sync1;
    logic [P_WIDTH-1:0] r_sync2;
    logic [P_WIDTH-1:0] r_cmp;
    logic [19:0]        r_presc;
    logic [3:0]         r_dcnt [P_WIDTH];
    logic [P_WIDTH-1:0] r_deb;
    logic [P_WIDTH-1:0] r_prev;
    logic [P_WIDTH-1:0] r_commit;
    logic [P_WIDTH-1:0] r_data;
    logic [7:0]         r_settle;
    logic               r_req;
    logic               r_valid;
    state_t             r_state;

    logic               w_tick;
    logic               w_all_stable;

    assign w_tick = (r_presc == P_TICK);

    // Two-flop synchroniser per switch, then one compare flop to detect movement.
    always_ff @(posedge SYS_CLK or negedge SYS_xRST) begin
        if (!SYS_xRST) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_cmp   <= '0;
        end else begin
            r_sync1 <= if_cfg.SW_IN;
            r_sync2 <= r_sync1;
            r_cmp   <= r_sync2;
        end
    end

    // Free-running millisecond prescaler shared by all channels and the settle timer.
    always_ff @(posedge SYS_CLK or negedge SYS_xRST) begin
        if (!SYS_xRST) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 20'd1;
        end
    end

    // Per-channel stability counter; the debounced bit follows only after P_STABLE quiet ticks.
    always_ff @(posedge SYS_CLK or negedge SYS_xRST) begin
        if (!SYS_xRST) begin
            for (int i = 0; i < P_WIDTH; i++) begin
                r_dcnt[i] <= '0;
            end
            r_deb <= '0;
        end else begin
            for (int i = 0; i < P_WIDTH; i++) begin
                if (r_sync2[i] != r_cmp[i]) begin
                    r_dcnt[i] <= '0;
                end else if (w_tick && (r_dcnt[i] != P_STABLE)) begin
                    r_dcnt[i] <= r_dcnt[i] + 4'd1;
                end
                if (r_dcnt[i] == P_STABLE) begin
                    r_deb[i] <= r_cmp[i];
                end
            end
        end
    end

    // All channels have reached their stable count.
    always_comb begin
        w_all_stable = 1'b1;
        for (int i = 0; i < P_WIDTH; i++) begin
            if (r_dcnt[i] != P_STABLE) begin
                w_all_stable = 1'b0;
            end
        end
    end

    // Commit FSM: initial commit after reset, then settle-and-commit on every debounced change.
    always_ff @(posedge SYS_CLK or negedge SYS_xRST) begin
        if (!SYS_xRST) begin
            r_state  <= S_INIT;
            r_prev   <= '0;
            r_commit <= '0;
            r_data   <= '0;
            r_settle <= '0;
            r_req    <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_prev <= r_deb;
            case (r_state)
                S_INIT: begin
                    // Debounced bits lag the counters by a cycle; wait until they have caught up.
                    if (w_all_stable && (r_deb == r_cmp)) begin
                        r_data  <= r_deb;
                        r_req   <= 1'b1;
                        r_state <= S_REQ;
                    end
                end
                S_IDLE: begin
                    if (r_deb != r_commit) begin
                        r_settle <= '0;
                        r_state  <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (r_deb == r_commit) begin
                        r_state <= S_IDLE;
                    end else if (r_deb != r_prev) begin
                        r_settle <= '0;
                    end else if (r_settle == P_SETTLE) begin
                        r_data  <= r_deb;
                        r_req   <= 1'b1;
                        r_state <= S_REQ;
                    end else if (w_tick) begin
                        r_settle <= r_settle + 8'd1;
                    end
                end
                S_REQ: begin
                    if (if_cfg.CFG_ACK) begin
                        r_commit <= r_data;
                        r_valid  <= 1'b1;
                        r_req    <= 1'b0;
                        r_state  <= S_ACKLOW;
                    end
                end
                S_ACKLOW: begin
                    if (!if_cfg.CFG_ACK) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_INIT;
                end
            endcase
        end
    end

    assign if_cfg.CFG_REQ   = r_req;
    assign if_cfg.CFG_DATA  = r_data;
    assign if_cfg.CFG_VALID = r_valid;
    assign if_cfg.SW_STATE  = r_deb;

endmodule
